// File: rtl/vec_cache_tag_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : vec_cache_tag_wr_ctrl
//  Brief   : Drains the write-tag buffer into the single-port tag SRAM.
//  Revision: 1.0
// ============================================================================
module vec_cache_tag_wr_ctrl #(
  parameter int INDEX_W    = 8,
  parameter int TAG_W      = 20,
  parameter int WAY_NUM    = 8,
  parameter int STARVE_MAX = 8,
  localparam int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
  localparam int PLD_W     = INDEX_W + TAG_W + WAY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_tag_buf_vld,
  input  logic [PLD_W-1:0]   wr_tag_buf_pld,   // {index, tag, way}
  output logic               buf_clean_en,
  input  logic               rd_req_vld,
  input  logic [INDEX_W-1:0] rd_req_index,
  output logic               rd_req_rdy,
  output logic               rd_hazard,
  output logic               tag_ram_wr_en,
  output logic [INDEX_W-1:0] tag_ram_wr_index,
  output logic [WAY_NUM-1:0] tag_ram_wr_way_en,
  output logic [TAG_W:0]     tag_ram_wr_data,
  output logic               tag_wr_busy,
  output logic               tag_wr_done
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [CNT_W-1:0]   w_starve_cnt_nxt;
  logic               w_capture;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [WAY_W-1:0]   r_way;

  logic [INDEX_W-1:0] w_pld_index;
  logic [TAG_W-1:0]   w_pld_tag;
  logic [WAY_W-1:0]   w_pld_way;
  logic               w_idle;
  logic               w_write;
  logic               w_starved;
  logic               w_rd_ok;

  assign {w_pld_index, w_pld_tag, w_pld_way} = wr_tag_buf_pld;

  assign w_idle    = (r_state == S_IDLE);
  assign w_write   = (r_state == S_WRITE);
  assign w_starved = (r_state == S_WAIT) && (r_starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // The buffer payload flop re-samples every cycle, so it is only trusted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= '0;
      r_tag   <= '0;
      r_way   <= '0;
    end else if (w_capture) begin
      r_index <= w_pld_index;
      r_tag   <= w_pld_tag;
      r_way   <= w_pld_way;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_starve_cnt_nxt = r_starve_cnt;
    w_capture        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_tag_buf_vld) begin
          w_capture        = 1'b1;
          w_starve_cnt_nxt = '0;
          w_state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!rd_req_vld || w_starved) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
      end
      S_WRITE: w_state_nxt = S_CLEAN;
      S_CLEAN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In IDLE the hazard comes from the buffer itself, since nothing is latched yet.
  assign rd_hazard = rd_req_vld &
                     ((w_idle & wr_tag_buf_vld & (rd_req_index == w_pld_index)) |
                      (~w_idle & (rd_req_index == r_index)));

  assign w_rd_ok    = rd_req_vld & ~rd_hazard;
  assign rd_req_rdy = w_rd_ok & ~w_write & ~w_starved;

  assign tag_ram_wr_en     = w_write;
  assign tag_ram_wr_index  = w_write ? r_index : '0;
  assign tag_ram_wr_way_en = w_write ? (WAY_NUM'(1) << r_way) : '0;
  assign tag_ram_wr_data   = w_write ? {1'b1, r_tag} : '0;
  assign buf_clean_en      = (r_state == S_CLEAN);
  assign tag_wr_done       = (r_state == S_CLEAN);
  assign tag_wr_busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_vec_cache_tag_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vec_cache_tag_wr_ctrl
//  Brief   : Directed self-checking bench for vec_cache_tag_wr_ctrl.
//  Revision: 1.0
// ============================================================================
module tb_vec_cache_tag_wr_ctrl;

  localparam int INDEX_W    = 8;
  localparam int TAG_W      = 20;
  localparam int WAY_NUM    = 8;
  localparam int STARVE_MAX = 8;
  localparam int PLD_W      = INDEX_W + TAG_W + 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               wr_tag_buf_vld = 1'b0;
  logic [PLD_W-1:0]   wr_tag_buf_pld = '0;
  logic               buf_clean_en;
  logic               rd_req_vld = 1'b0;
  logic [INDEX_W-1:0] rd_req_index = '0;
  logic               rd_req_rdy;
  logic               rd_hazard;
  logic               tag_ram_wr_en;
  logic [INDEX_W-1:0] tag_ram_wr_index;
  logic [WAY_NUM-1:0] tag_ram_wr_way_en;
  logic [TAG_W:0]     tag_ram_wr_data;
  logic               tag_wr_busy;
  logic               tag_wr_done;

  int n_cmp = 0;
  int n_bad = 0;

  vec_cache_tag_wr_ctrl #(
    .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WAY_NUM(WAY_NUM), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_tag_buf_vld(wr_tag_buf_vld), .wr_tag_buf_pld(wr_tag_buf_pld),
    .buf_clean_en(buf_clean_en),
    .rd_req_vld(rd_req_vld), .rd_req_index(rd_req_index),
    .rd_req_rdy(rd_req_rdy), .rd_hazard(rd_hazard),
    .tag_ram_wr_en(tag_ram_wr_en), .tag_ram_wr_index(tag_ram_wr_index),
    .tag_ram_wr_way_en(tag_ram_wr_way_en), .tag_ram_wr_data(tag_ram_wr_data),
    .tag_wr_busy(tag_wr_busy), .tag_wr_done(tag_wr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [PLD_W-1:0] pld(input logic [7:0] idx, input logic [19:0] tag,
                                           input logic [2:0] way);
    return {idx, tag, way};
  endfunction

  // Steps until the clean pulse, then drops the buffer valid for the following IDLE cycle.
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (buf_clean_en) begin
        ok = 1'b1;
        @(negedge clk);
        wr_tag_buf_vld = 1'b0;
        #1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (tag_wr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", tag_wr_busy); end
    n_cmp++; if (tag_ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", tag_ram_wr_en); end
    n_cmp++; if (buf_clean_en !== 1'b0 || tag_wr_done !== 1'b0) begin n_bad++; $display("FAIL reset_clean: got %b/%b want 0/0", buf_clean_en, tag_wr_done); end
    n_cmp++; if (tag_ram_wr_way_en !== 8'h00 || tag_ram_wr_data !== 21'h0 || tag_ram_wr_index !== 8'h00) begin
      n_bad++; $display("FAIL reset_wr_bus: got %h/%h/%h want 0/0/0", tag_ram_wr_index, tag_ram_wr_way_en, tag_ram_wr_data);
    end
    n_cmp++; if (rd_req_rdy !== 1'b0 || rd_hazard !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b/%b want 0/0", rd_req_rdy, rd_hazard); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_min_latency();
    @(negedge clk); wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'hABC, 3'd3); #1;
    n_cmp++; if (tag_wr_busy !== 1'b0 || tag_ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL min_c0: busy/wr_en %b/%b want 0/0", tag_wr_busy, tag_ram_wr_en); end
    @(negedge clk); #1;
    n_cmp++; if (tag_wr_busy !== 1'b1 || tag_ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL min_c1: busy/wr_en %b/%b want 1/0", tag_wr_busy, tag_ram_wr_en); end
    @(negedge clk); #1;
    n_cmp++; if (tag_ram_wr_en !== 1'b1 || buf_clean_en !== 1'b0) begin n_bad++; $display("FAIL min_wr_en: wr_en/clean %b/%b want 1/0", tag_ram_wr_en, buf_clean_en); end
    n_cmp++; if (tag_ram_wr_index !== 8'd5) begin n_bad++; $display("FAIL min_index: got %h want 05", tag_ram_wr_index); end
    n_cmp++; if (tag_ram_wr_way_en !== 8'h08) begin n_bad++; $display("FAIL min_way_en: got %h want 08", tag_ram_wr_way_en); end
    n_cmp++; if (tag_ram_wr_data !== 21'h100ABC) begin n_bad++; $display("FAIL min_data: got %h want 100abc", tag_ram_wr_data); end
    @(negedge clk); #1;
    n_cmp++; if (buf_clean_en !== 1'b1 || tag_wr_done !== 1'b1 || tag_ram_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL min_clean: clean/done/wr_en %b/%b/%b want 1/1/0", buf_clean_en, tag_wr_done, tag_ram_wr_en);
    end
    @(negedge clk); wr_tag_buf_vld = 1'b0; #1;
    n_cmp++; if (tag_wr_busy !== 1'b0 || buf_clean_en !== 1'b0) begin n_bad++; $display("FAIL min_idle: busy/clean %b/%b want 0/0", tag_wr_busy, buf_clean_en); end
  endtask

  task automatic test_starvation();
    int first_nrdy, wr_cnt, wr_at, clean_cnt, clean_at;
    first_nrdy = -1; wr_cnt = 0; wr_at = -1; clean_cnt = 0; clean_at = -1;
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'hABC, 3'd3);
    rd_req_vld = 1'b1; rd_req_index = 8'd7;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (clean_at == c - 1) wr_tag_buf_vld = 1'b0;
      end
      #1;
      if (!rd_req_rdy && first_nrdy < 0) first_nrdy = c;
      if (tag_ram_wr_en) begin wr_cnt++; wr_at = c; end
      if (buf_clean_en) begin clean_cnt++; clean_at = c; end
    end
    rd_req_vld = 1'b0;
    n_cmp++; if (first_nrdy !== 9) begin n_bad++; $display("FAIL starve_rdy_cycles: first rdy=0 at %0d want 9", first_nrdy); end
    n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL starve_wr_count: got %0d want 1", wr_cnt); end
    n_cmp++; if (wr_at !== 10) begin n_bad++; $display("FAIL starve_wr_cycle: got %0d want 10", wr_at); end
    n_cmp++; if (clean_cnt !== 1 || clean_at !== 11) begin n_bad++; $display("FAIL starve_clean: count %0d at %0d want 1 at 11", clean_cnt, clean_at); end
  endtask

  task automatic test_hazard();
    bit reached_idle, ok;
    int prev_clean;
    reached_idle = 1'b0; prev_clean = 0;
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'h0055, 3'd1);
    rd_req_vld = 1'b1; rd_req_index = 8'd5;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (prev_clean != 0) wr_tag_buf_vld = 1'b0;
      end
      #1;
      if (c > 0 && !tag_wr_busy) begin reached_idle = 1'b1; break; end
      n_cmp++;
      if (rd_hazard !== 1'b1 || rd_req_rdy !== 1'b0) begin
        n_bad++; $display("FAIL hazard_c%0d: hazard/rdy %b/%b want 1/0", c, rd_hazard, rd_req_rdy);
      end
      prev_clean = int'(buf_clean_en);
    end
    n_cmp++; if (!reached_idle) begin n_bad++; $display("FAIL hazard_timeout: busy %b want 0", tag_wr_busy); end
    n_cmp++; if (rd_hazard !== 1'b0 || rd_req_rdy !== 1'b1) begin n_bad++; $display("FAIL hazard_cleared: hazard/rdy %b/%b want 0/1", rd_hazard, rd_req_rdy); end
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'h0055, 3'd1); rd_req_index = 8'd6; #1;
    n_cmp++; if (rd_hazard !== 1'b0 || rd_req_rdy !== 1'b1) begin n_bad++; $display("FAIL nohaz_idle: hazard/rdy %b/%b want 0/1", rd_hazard, rd_req_rdy); end
    @(negedge clk); #1;
    n_cmp++; if (rd_hazard !== 1'b0 || rd_req_rdy !== 1'b1 || tag_wr_busy !== 1'b1) begin
      n_bad++; $display("FAIL nohaz_wait: hazard/rdy/busy %b/%b/%b want 0/1/1", rd_hazard, rd_req_rdy, tag_wr_busy);
    end
    rd_req_vld = 1'b0;
    drain(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL nohaz_drain: clean seen %b want 1", ok); end
  endtask

  task automatic test_back_to_back();
    int wr_cnt, clean_cnt;
    logic [7:0] idx0, idx1;
    logic [7:0] way1;
    logic [20:0] data1;
    wr_cnt = 0; clean_cnt = 0; idx0 = '0; idx1 = '0; way1 = '0; data1 = '0;
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'hABC, 3'd3);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) wr_tag_buf_pld = pld(8'd9, 20'h12345, 3'd0);
      if (c == 8) wr_tag_buf_vld = 1'b0;
      #1;
      if (tag_ram_wr_en) begin
        if (wr_cnt == 0) idx0 = tag_ram_wr_index;
        else begin idx1 = tag_ram_wr_index; way1 = tag_ram_wr_way_en; data1 = tag_ram_wr_data; end
        wr_cnt++;
      end
      if (buf_clean_en) clean_cnt++;
    end
    n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want 2", wr_cnt); end
    n_cmp++; if (clean_cnt !== 2) begin n_bad++; $display("FAIL b2b_clean_count: got %0d want 2", clean_cnt); end
    n_cmp++; if (idx0 !== 8'd5 || idx1 !== 8'd9) begin n_bad++; $display("FAIL b2b_index: got %h,%h want 05,09", idx0, idx1); end
    n_cmp++; if (way1 !== 8'h01 || data1 !== 21'h112345) begin n_bad++; $display("FAIL b2b_second: way_en/data %h/%h want 01/112345", way1, data1); end
  endtask

  task automatic test_capture_hold();
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'hABC, 3'd3); #1;
    @(negedge clk);
    wr_tag_buf_vld = 1'b0; wr_tag_buf_pld = pld(8'h33, 20'hFFFFF, 3'd7); #1;
    @(negedge clk); #1;
    n_cmp++; if (tag_ram_wr_en !== 1'b1 || tag_ram_wr_index !== 8'd5) begin n_bad++; $display("FAIL hold_index: wr_en/index %b/%h want 1/05", tag_ram_wr_en, tag_ram_wr_index); end
    n_cmp++; if (tag_ram_wr_way_en !== 8'h08 || tag_ram_wr_data !== 21'h100ABC) begin
      n_bad++; $display("FAIL hold_data: way_en/data %h/%h want 08/100abc", tag_ram_wr_way_en, tag_ram_wr_data);
    end
    @(negedge clk); #1;
    n_cmp++; if (buf_clean_en !== 1'b1) begin n_bad++; $display("FAIL hold_clean: got %b want 1", buf_clean_en); end
    @(negedge clk); #1;
    n_cmp++; if (tag_wr_busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle: busy %b want 0", tag_wr_busy); end
  endtask

  task automatic test_reset_mid();
    int bad_pulses;
    bad_pulses = 0;
    @(negedge clk);
    wr_tag_buf_vld = 1'b1; wr_tag_buf_pld = pld(8'd5, 20'hABC, 3'd3);
    rd_req_vld = 1'b1; rd_req_index = 8'd7;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (tag_wr_busy !== 1'b1 || tag_ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_wait: busy/wr_en %b/%b want 1/0", tag_wr_busy, tag_ram_wr_en); end
    #1 rst_n = 1'b0; wr_tag_buf_vld = 1'b0; rd_req_vld = 1'b0; #1;
    n_cmp++; if (tag_wr_busy !== 1'b0 || tag_ram_wr_en !== 1'b0 || buf_clean_en !== 1'b0 || tag_wr_done !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_outputs: busy/wr_en/clean/done %b/%b/%b/%b want 0/0/0/0", tag_wr_busy, tag_ram_wr_en, buf_clean_en, tag_wr_done);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (tag_ram_wr_en || buf_clean_en) bad_pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (tag_ram_wr_en || buf_clean_en || tag_wr_busy) bad_pulses++;
    end
    n_cmp++; if (bad_pulses !== 0) begin n_bad++; $display("FAIL rstmid_no_write: %0d active cycles want 0", bad_pulses); end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_starvation();
    test_hazard();
    test_back_to_back();
    test_capture_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
